// File: rtl/ysyx_23060025_burst_rd_responder_pkg.sv
// Shared definitions for the instruction-cache refill burst read responder.
//   - FSM state encoding
//   - legal beat size (4-byte AXI size code)
//   - seed, taps and step function of the optional stall LFSR
//     (enabled by the BURST_RD_STALL_EN macro in the top module)
package ysyx_23060025_burst_rd_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_BURST = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    // AXI size code for 4-byte beats; the only size this responder serves.
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    // x^16+x^14+x^13+x^11+1 in right-shifting form: the feedback bit is the
    // XOR of state bits 0, 2, 3 and 5 and enters at bit 15.
    localparam logic [15:0] STALL_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] STALL_LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] stall_lfsr_next(input logic [15:0] s);
        return {^(s & STALL_LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/ysyx_23060025_sram_1r1w.sv
// Word-addressed single-clock SRAM, one read port and one write port.
//   clock           : clock
//   rd_en / rd_addr : read request; data appears on rd_data after the edge
//   rd_data         : read data, holds its value while rd_en is low
//   wr_en / wr_addr / wr_data : write port
// A read and a write to the same word in the same cycle returns the old
// word (read-before-write). The array is never reset.
module ysyx_23060025_sram_1r1w #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_data_q;

    // Both ports use non-blocking updates, so a same-cycle read samples the
    // array before the write lands.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ysyx_23060025_burst_rd_responder.sv
// Memory-side responder for the instruction-cache refill interface.
// Takes a level-held burst read request and returns arlen+1 beats of 32-bit
// data from an internal SRAM, first beat FIRST_LAT cycles after capture,
// then one beat per cycle, rlast on the final beat. No backpressure.
//   clock, reset                 : clock, async active-low reset
//   in_paddr/in_psel/in_arlen/in_arsize : burst request (held while psel=1)
//   out_rvalid/out_rlast/out_rdata/out_rerr : beat outputs
//   wr_en/wr_addr/wr_data        : SRAM preload write port
// Optional: define BURST_RD_STALL_EN to insert LFSR-driven bubbles between
// beats (never more than 3 in a row).
module ysyx_23060025_burst_rd_responder
    import ysyx_23060025_burst_rd_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 12,
    parameter int FIRST_LAT  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] in_paddr,
    input  logic                  in_psel,
    input  logic [7:0]            in_arlen,
    input  logic [2:0]            in_arsize,
    output logic                  out_rvalid,
    output logic                  out_rlast,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic                  out_rerr,
    input  logic                  wr_en,
    input  logic [MEM_AW-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam logic [3:0]        LAT_INIT = 4'(FIRST_LAT - 1);
    localparam logic [MEM_AW-1:0] IDX_ONE  = 1;

    state_e                state_q, state_d;
    logic [MEM_AW-1:0]     idx_q, idx_d;
    logic [7:0]            rem_q, rem_d;
    logic [3:0]            lat_q, lat_d;
    logic                  err_q, err_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic                  rerr_q, rerr_d;
    logic                  issue;
    logic                  stall;
    logic [DATA_WIDTH-1:0] sram_rdata;

    // Byte-offset and high address bits do not select a word.
    logic unused_paddr_bits;
    assign unused_paddr_bits = ^{in_paddr[ADDR_WIDTH-1:MEM_AW+2], in_paddr[1:0]};

`ifdef BURST_RD_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  bub_q, bub_d;

    assign lfsr_d = stall_lfsr_next(lfsr_q);
    // A bubble is only allowed while fewer than 3 have been taken in a row.
    assign stall  = lfsr_q[0] && (bub_q != 2'd3);
    assign bub_d  = (state_q == S_BURST && in_psel && stall) ? bub_q + 2'd1 : 2'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= STALL_LFSR_SEED;
            bub_q  <= 2'd0;
        end else begin
            lfsr_q <= lfsr_d;
            bub_q  <= bub_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        lat_d    = lat_q;
        err_d    = err_q;
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
        rerr_d   = 1'b0;
        issue    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_psel) begin
                    idx_d   = in_paddr[MEM_AW+1:2];
                    rem_d   = in_arlen;
                    err_d   = (in_arsize != AXI_SIZE_4B);
                    lat_d   = LAT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // The first read is issued in the last WAIT cycle so the
                // registered beat lands exactly FIRST_LAT edges after capture.
                if (!in_psel) begin
                    state_d = S_IDLE;
                end else if (lat_q == 4'd0) begin
                    issue   = 1'b1;
                    state_d = S_BURST;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_BURST: begin
                if (!in_psel) begin
                    state_d = S_IDLE;
                end else if (!stall) begin
                    issue = 1'b1;
                end
            end
            S_DONE: begin
                if (!in_psel) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A beat issued this cycle is presented on the outputs next cycle.
        if (issue) begin
            rvalid_d = 1'b1;
            rerr_d   = err_q;
            rlast_d  = (rem_q == 8'd0);
            idx_d    = idx_q + IDX_ONE;
            rem_d    = rem_q - 8'd1;
            if (rem_q == 8'd0) state_d = S_DONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            rem_q    <= 8'd0;
            lat_q    <= 4'd0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
            lat_q    <= lat_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            rerr_q   <= rerr_d;
        end
    end

    ysyx_23060025_sram_1r1w #(
        .AW (MEM_AW),
        .DW (DATA_WIDTH)
    ) u_sram (
        .clock   (clock),
        .rd_en   (issue),
        .rd_addr (idx_q),
        .rd_data (sram_rdata),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // The SRAM output register is not reset, so data is gated by the reset
    // flops; error beats carry zero data.
    assign out_rvalid = rvalid_q;
    assign out_rlast  = rlast_q;
    assign out_rerr   = rerr_q;
    assign out_rdata  = (rvalid_q && !rerr_q) ? sram_rdata : '0;

endmodule

// File: tb/tb_ysyx_23060025_burst_rd_responder.sv
// Self-checking bench for ysyx_23060025_burst_rd_responder. A word-array
// model of memory predicts each burst's beats; bursts are directed and
// random. Honors BURST_RD_STALL_EN for the inter-beat gap rule.
module tb_ysyx_23060025_burst_rd_responder;

    localparam int FL = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic [7:0]  in_arlen;
    logic [2:0]  in_arsize;
    logic        out_rvalid;
    logic        out_rlast;
    logic [31:0] out_rdata;
    logic        out_rerr;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_mem [0:4095];

    always #5 clock = ~clock;

    ysyx_23060025_burst_rd_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_AW     (12),
        .FIRST_LAT  (FL)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_paddr   (in_paddr),
        .in_psel    (in_psel),
        .in_arlen   (in_arlen),
        .in_arsize  (in_arsize),
        .out_rvalid (out_rvalid),
        .out_rlast  (out_rlast),
        .out_rdata  (out_rdata),
        .out_rerr   (out_rerr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mem_write(input logic [11:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        ref_mem[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Runs one complete burst from IDLE and checks every beat against the
    // model. wmode 1: write the last beat's word right after capture (new
    // data expected). wmode 2: write the first word in the very cycle its
    // read is issued (old data expected).
    task automatic run_burst(input string name, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input int wmode, input logic [31:0] wdata);
        logic [11:0] base, tgt;
        logic [31:0] exp_d [$];
        int          got, i, gap;
        bit          last_seen;
        base = addr[13:2];
        tgt  = (wmode == 2) ? base : base + 12'(len);
        if (wmode == 1) ref_mem[tgt] = wdata;
        for (int k = 0; k <= int'(len); k++) begin
            logic [11:0] a;
            a = base + 12'(k);
            exp_d.push_back((size == 3'b010) ? ref_mem[a] : 32'h0);
        end
        in_paddr  = addr;
        in_arlen  = len;
        in_arsize = size;
        in_psel   = 1'b1;
        got = 0; gap = 0; last_seen = 0; i = 0;
        tick();
        while (!last_seen && i < 1000) begin
            wr_en = 1'b0;
            if ((wmode == 1 && i == 0) || (wmode == 2 && i == FL - 1)) begin
                wr_en   = 1'b1;
                wr_addr = tgt;
                wr_data = wdata;
            end
            tick();
            i++;
            if (out_rvalid) begin
                if (got == 0) begin
                    n_checks++;
                    if (i != FL) begin
                        n_errors++;
                        $display("FAIL %s first_latency: got %0d cycles, expected %0d", name, i, FL);
                    end
                end else begin
                    n_checks++;
`ifdef BURST_RD_STALL_EN
                    if (gap > 3) begin
`else
                    if (gap != 0) begin
`endif
                        n_errors++;
                        $display("FAIL %s beat_gap: %0d bubbles before beat %0d", name, gap, got);
                    end
                end
                gap = 0;
                if (got < exp_d.size()) begin
                    n_checks++;
                    if (out_rdata !== exp_d[got]) begin
                        n_errors++;
                        $display("FAIL %s rdata beat %0d: got %h, expected %h", name, got, out_rdata, exp_d[got]);
                    end
                    n_checks++;
                    if (out_rerr !== (size != 3'b010)) begin
                        n_errors++;
                        $display("FAIL %s rerr beat %0d: got %b, expected %b", name, got, out_rerr, size != 3'b010);
                    end
                    n_checks++;
                    if (out_rlast !== (got == int'(len))) begin
                        n_errors++;
                        $display("FAIL %s rlast beat %0d: got %b, expected %b", name, got, out_rlast, got == int'(len));
                    end
                end
                if (out_rlast === 1'b1) last_seen = 1;
                got++;
            end else begin
                if (got > 0) gap++;
                n_checks++;
                if (out_rlast !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s rlast_without_rvalid: got %b, expected 0", name, out_rlast);
                end
            end
        end
        wr_en = 1'b0;
        n_checks++;
        if (!last_seen) begin
            n_errors++;
            $display("FAIL %s timeout: no rlast after %0d cycles, expected rlast", name, i);
        end
        n_checks++;
        if (got != int'(len) + 1) begin
            n_errors++;
            $display("FAIL %s beat_count: got %0d, expected %0d", name, got, int'(len) + 1);
        end
        // psel still high: responder must sit in DONE and not restart.
        repeat (2) begin
            tick();
            n_checks++;
            if (out_rvalid !== 1'b0 || out_rlast !== 1'b0 || out_rerr !== 1'b0) begin
                n_errors++;
                $display("FAIL %s done_hold: got v=%b l=%b e=%b, expected all 0", name, out_rvalid, out_rlast, out_rerr);
            end
        end
        in_psel = 1'b0;
        tick();
        if (wmode == 2) ref_mem[tgt] = wdata;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_psel = 1'b0; in_paddr = '0; in_arlen = '0;
        in_arsize = 3'b010; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #3;
        n_checks++;
        if (out_rvalid !== 1'b0 || out_rlast !== 1'b0 || out_rerr !== 1'b0 || out_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_state: got v=%b l=%b e=%b d=%h, expected all 0", out_rvalid, out_rlast, out_rerr, out_rdata);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_preload();
        for (int k = 0; k < 4096; k++) begin
            wr_en   = 1'b1;
            wr_addr = 12'(k);
            wr_data = $urandom;
            ref_mem[k] = wr_data;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_basic();
        mem_write(12'h100, 32'h11);
        mem_write(12'h101, 32'h22);
        mem_write(12'h102, 32'h33);
        mem_write(12'h103, 32'h44);
        run_burst("basic4", 32'h400, 8'd3, 3'b010, 0, 32'h0);
    endtask

    task automatic test_single();
        mem_write(12'h101, 32'hDEAD_BEEF);
        run_burst("single", 32'h404, 8'd0, 3'b010, 0, 32'h0);
    endtask

    task automatic test_wrap();
        run_burst("wrap", 32'h3FF8, 8'd3, 3'b010, 0, 32'h0);
    endtask

    task automatic test_bad_size();
        run_burst("bad_size", 32'h200, 8'd1, 3'b011, 0, 32'h0);
        run_burst("after_bad", 32'h200, 8'd1, 3'b010, 0, 32'h0);
    endtask

    task automatic test_write_during_burst();
        run_burst("wr_earlier", 32'h800, 8'd3, 3'b010, 1, 32'hCAFE_0001);
        run_burst("wr_same_cycle", 32'h900, 8'd2, 3'b010, 2, 32'hCAFE_0002);
        run_burst("wr_same_cycle_check", 32'h900, 8'd0, 3'b010, 0, 32'h0);
    endtask

    task automatic test_long();
        run_burst("len16", 32'h1000, 8'd15, 3'b010, 0, 32'h0);
        run_burst("len256", 32'h3C00, 8'd255, 3'b010, 0, 32'h0);
    endtask

    task automatic test_abort();
        int  i;
        bit  seen;
        in_paddr = 32'h600; in_arlen = 8'd3; in_arsize = 3'b010; in_psel = 1'b1;
        seen = 0; i = 0;
        tick();
        while (!seen && i < 50) begin
            tick();
            i++;
            if (out_rvalid) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL abort timeout: no beat after %0d cycles, expected a beat", i);
        end
        in_psel = 1'b0;
        repeat (3) begin
            tick();
            n_checks++;
            if (out_rvalid !== 1'b0 || out_rlast !== 1'b0) begin
                n_errors++;
                $display("FAIL abort outputs: got v=%b l=%b, expected 0 0", out_rvalid, out_rlast);
            end
        end
        run_burst("after_abort", 32'h600, 8'd3, 3'b010, 0, 32'h0);
    endtask

    task automatic test_async_reset();
        int got, i;
        in_paddr = 32'h700; in_arlen = 8'd7; in_arsize = 3'b010; in_psel = 1'b1;
        got = 0; i = 0;
        tick();
        while (got < 2 && i < 50) begin
            tick();
            i++;
            if (out_rvalid) got++;
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (out_rvalid !== 1'b0 || out_rlast !== 1'b0 || out_rerr !== 1'b0 || out_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL async_reset: got v=%b l=%b e=%b d=%h, expected all 0 (beats seen %0d)", out_rvalid, out_rlast, out_rerr, out_rdata, got);
        end
        in_psel = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        run_burst("after_reset", 32'h700, 8'd7, 3'b010, 0, 32'h0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            logic [31:0] a;
            logic [7:0]  l;
            logic [2:0]  s;
            a = $urandom;
            l = 8'($urandom_range(0, 20));
            s = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b010;
            run_burst($sformatf("rand%0d", n), a, l, s, int'($urandom_range(0, 2)), $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_basic();
        test_single();
        test_wrap();
        test_bad_size();
        test_write_during_burst();
        test_long();
        test_abort();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060025_burst_rd_responder.md
Name: ysyx_23060025_burst_rd_responder

Overview:
- Memory-side responder for the instruction-cache refill interface.
- Accepts a level-held burst read request (paddr/psel/arlen/arsize) and returns beats as rdata, qualified by rvalid, with rlast on the final beat.
- There is no backpressure: the responder paces all beats.
- Backed by a word-addressed single-clock SRAM with a side write port, used for program preload by the testbench or loader.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, beat width; only 32 is supported.
- MEM_AW, 12, log2 of SRAM depth in words (4096 words).
- FIRST_LAT, 2, cycles from request capture to the first beat; allowed range 1..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_paddr  in  32  burst start byte address; held stable while in_psel is high.
- in_psel  in  1  request; rises to start, stays high until the cycle after the rlast beat.
- in_arlen  in  8  beats minus 1.
- in_arsize  in  3  beat size; only 3'b010 (4 bytes) is legal.
- out_rvalid  out  1  beat valid.
- out_rlast  out  1  final beat of the burst; only meaningful with out_rvalid.
- out_rdata  out  32  beat data.
- out_rerr  out  1  error flag on every beat of a burst with illegal in_arsize.
- wr_en  in  1  preload write strobe.
- wr_addr  in  MEM_AW  preload word index.
- wr_data  in  32  preload data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; out_rvalid, out_rlast and out_rerr are 0; out_rdata is 0.
  - SRAM contents are not reset.
- State IDLE:
  - On in_psel=1, capture the start word index = in_paddr[MEM_AW+1:2] and beat count = in_arlen.
  - Set the error latch = (in_arsize != 3'b010).
  - Load the latency counter with FIRST_LAT-1, then go to WAIT.
  - in_paddr[1:0] is ignored.
- State WAIT:
  - Decrement the counter each cycle.
  - At 0, go to BURST and issue the SRAM read for the first word, so that the first out_rvalid appears exactly FIRST_LAT cycles after the capture edge.
- State BURST, one beat per cycle:
  - out_rvalid=1 and out_rdata=mem[idx].
  - idx increments by 1 modulo 2^MEM_AW; the burst wraps at the top of memory with no error.
  - out_rlast=1 when the remaining count is 0, then go to DONE.
  - in_arlen=0 gives a single beat with rlast=1.
  - in_arlen=255 gives 256 beats.
- State DONE:
  - Outputs are low.
  - Return to IDLE when in_psel=0, and only then; a new request is never taken from DONE in the same cycle.
  - The initiator drops psel the cycle after rlast, so the minimum gap between bursts is 1 idle cycle.
- Illegal size:
  - The beat count and timing are unchanged.
  - out_rdata=0 and out_rerr=1 on every beat.
- in_psel dropping mid-burst (in WAIT or BURST) is a protocol error:
  - Abort, drive outputs low and return to IDLE next cycle.
  - No rlast is issued.
- Writes during a burst are allowed:
  - A read sees writes completed in earlier cycles.
  - A write to the same word in the same cycle that word's read is issued returns the old data (read-before-write).
- Outputs are registered; no combinational path exists from any input to any output.

Optional Feature:
- Macro: BURST_RD_STALL_EN.
- When defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) runs continuously.
  - In BURST, a cycle with lfsr[0]=1 inserts a bubble: out_rvalid=0, idx and count hold.
  - At most 3 consecutive bubbles; the 4th cycle is forced to be a beat.
  - Beat order, data and rlast placement are unchanged.
- When undefined: no LFSR is present, and beats are back-to-back as described above.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'b00, WAIT=2'b01, BURST=2'b10, DONE=2'b11.
  - The legal size constant (the existing 4-byte AXI size define).
  - The stall LFSR seed and taps.
- One sub-module: ysyx_23060025_sram_1r1w.
  - Parameterised by AW and DW.
  - Synchronous read with 1-cycle latency, read-before-write, no reset on the array.
- The responder FSM, counters and output registers live in the top module.

Test Plan:
- Preload mem[0x100..0x103]=32'h11,22,33,44; request paddr=0x400, arlen=3, arsize=2 with FIRST_LAT=2 -> first rvalid 2 cycles after capture; data 11,22,33,44 on consecutive cycles; rlast only on 44; rerr=0.
- arlen=0, paddr=0x404, mem[0x101]=32'hDEAD_BEEF -> exactly one beat DEADBEEF with rlast=1.
- Wrap: MEM_AW=12, paddr=0x3FF8, arlen=3 -> beats from word indices 0xFFE, 0xFFF, 0x000, 0x001.
- arsize=3'b011, arlen=1 -> two beats with rdata=0, rerr=1, rlast on the second; then psel low returns to IDLE; a following legal burst has rerr=0.
- Mid-burst in_psel drop after beat 1 of arlen=3, plus async reset asserted mid-BURST -> psel drop: outputs low the next cycle, no rlast, idle. Reset: outputs 0 immediately without a clock; after release a new request behaves normally.
- With BURST_RD_STALL_EN, arlen=15 -> 16 beats, data in order, never more than 3 consecutive bubbles, rlast on the 16th beat; the scoreboard matches the unstalled run.
